gb_joypad_reg: RTL and testbench

- Downstream consumer of the NES controller reader's 8-bit button vector.
- Synchronises and debounces the vector, then maps it onto the Game Boy P1 joypad register at FF00.
- Provides the CPU read/write access to P1, with select bits P14/P15.
- Raises the joypad interrupt request on any high-to-low transition of P10..P13.

---
 rtl/gb_joypad_pkg.sv | 27 ++
 rtl/gb_joypad_reg_if.sv | 14 +
 rtl/button_debouncer.sv | 44 ++++
 rtl/gb_joypad_reg.sv | 84 ++++++++
 tb/tb_gb_joypad_reg.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/gb_joypad_pkg.sv
// Shared constants for the Game Boy P1 joypad register block:
// button bit positions, bus address, reset value and the matrix helper.
package gb_joypad_pkg;

  // Bit positions within the 8-bit button vector (1 = pressed)
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam logic [15:0] P1_ADDR_DEFAULT = 16'hFF00;
  localparam logic [7:0]  P1_RESET_VALUE  = 8'hCF;
  localparam logic [1:0]  P1_UNUSED_BITS  = 2'b11;

  // Active-low key matrix: a select line that is high deselects its group,
  // so a deselected group contributes all-ones to the AND.
  function automatic logic [3:0] p1_nibble(input logic [1:0] sel,
                                           input logic [3:0] dir,
                                           input logic [3:0] btn);
    return (sel[0] ? 4'hF : dir) & (sel[1] ? 4'hF : btn);
  endfunction

endpackage

// File: rtl/gb_joypad_reg_if.sv
// CPU bus interface for the P1 register: address, write strobe and data
// from the CPU side, combinational read data and address hit back.
interface gb_joypad_reg_if;
  logic [15:0] I_ADDR;
  logic        I_WR_EN;
  logic [7:0]  I_WR_DATA;
  logic [7:0]  O_RD_DATA;
  logic        O_RD_HIT;

  modport master (output I_ADDR, I_WR_EN, I_WR_DATA,
                  input  O_RD_DATA, O_RD_HIT);
  modport slave  (input  I_ADDR, I_WR_EN, I_WR_DATA,
                  output O_RD_DATA, O_RD_HIT);
endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchroniser followed by a whole-vector debouncer: a new vector
// is committed only after it has been seen unchanged for DEBOUNCE_CYCLES
// consecutive cycles. The 16-bit counter saturates instead of wrapping.
module button_debouncer #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam logic [15:0] LAST_COUNT = 16'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] candidate;
  logic [15:0]      count;

  // Synchronise, track the candidate vector and commit it once stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= '0;
      s2        <= '0;
      candidate <= '0;
      count     <= '0;
      dout      <= '0;
    end else begin
      // NOTE: non-blocking assignments make s2 take the old s1, giving a true two-stage chain.
      s1 <= din;
      s2 <= s1;
      if (s2 != candidate) begin
        candidate <= s2;
        count     <= '0;
      end else if (count == LAST_COUNT) begin
        dout <= candidate;
      end else begin
        count <= count + 16'd1;
      end
    end
  end

endmodule

// File: rtl/gb_joypad_reg.sv
// Game Boy P1 (FF00) joypad register fed by a debounced NES button vector.
// Optional: define JOYPAD_SOCD_FILTER_EN to cancel opposing directions
// (Up+Down, Left+Right) before they reach the key matrix.
module gb_joypad_reg
  import gb_joypad_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 4096,
  parameter logic [15:0] P1_ADDR         = P1_ADDR_DEFAULT
) (
  input  logic               I_CLK,
  input  logic               I_RESET_N,
  input  logic [7:0]         I_BUTTONS,
  gb_joypad_reg_if.slave     bus,
  output logic               O_INT_REQ
);

  logic [7:0] stable;
  logic [7:0] filt;
  logic [3:0] dir;
  logic [3:0] btn;
  logic [3:0] nibble;
  logic [3:0] prev_nibble;
  logic [1:0] sel;
  logic       wr_data_unused;

  button_debouncer #(
    .WIDTH          (8),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk  (I_CLK),
    .rst_n(I_RESET_N),
    .din  (I_BUTTONS),
    .dout (stable)
  );

  // Optional cancellation of physically impossible direction pairs
  always_comb begin
    // NOTE: default assignment first so every path drives filt and no latch is inferred.
    filt = stable;
`ifdef JOYPAD_SOCD_FILTER_EN
    if (stable[BTN_UP] && stable[BTN_DOWN]) begin
      filt[BTN_UP]   = 1'b0;
      filt[BTN_DOWN] = 1'b0;
    end
    if (stable[BTN_LEFT] && stable[BTN_RIGHT]) begin
      filt[BTN_LEFT]  = 1'b0;
      filt[BTN_RIGHT] = 1'b0;
    end
`else
    // Opposing directions pass through unchanged
`endif
  end

  assign dir    = ~{filt[BTN_DOWN], filt[BTN_UP], filt[BTN_LEFT], filt[BTN_RIGHT]};
  assign btn    = ~{filt[BTN_START], filt[BTN_SELECT], filt[BTN_B], filt[BTN_A]};
  assign nibble = p1_nibble(sel, dir, btn);

  assign bus.O_RD_HIT  = (bus.I_ADDR == P1_ADDR);
  assign bus.O_RD_DATA = {P1_UNUSED_BITS, sel, nibble};

  // Only P15/P14 are writable; the other data bits are discarded
  assign wr_data_unused = ^{bus.I_WR_DATA[7:6], bus.I_WR_DATA[3:0]};

  // CPU write of the select lines
  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      sel <= 2'b00;
    end else if (bus.I_WR_EN && bus.O_RD_HIT) begin
      sel <= bus.I_WR_DATA[5:4];
    end
  end

  // Interrupt pulse on any high-to-low transition of P10..P13
  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      prev_nibble <= 4'hF;
      O_INT_REQ   <= 1'b0;
    end else begin
      prev_nibble <= nibble;
      O_INT_REQ   <= |(prev_nibble & ~nibble);
    end
  end

endmodule

// File: tb/tb_gb_joypad_reg.sv
// Self-checking bench for gb_joypad_reg with DEBOUNCE_CYCLES = 8.
// Expected outputs are queued when stimulus is applied and compared when
// the DUT is sampled on the falling clock edge.
module tb_gb_joypad_reg;
  import gb_joypad_pkg::*;

  localparam int DEB = 8;

  logic       clk;
  logic       rst_n;
  logic [7:0] buttons;
  logic       int_req;

  gb_joypad_reg_if bus ();

  gb_joypad_reg #(
    .DEBOUNCE_CYCLES(DEB),
    .P1_ADDR        (16'hFF00)
  ) dut (
    .I_CLK    (clk),
    .I_RESET_N(rst_n),
    .I_BUTTONS(buttons),
    .bus      (bus),
    .O_INT_REQ(int_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] rd;
    logic       hit;
    logic       irq;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   irq_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] rd,
                            input logic hit, input logic irq);
    exp_t e;
    e.tag = tag;
    e.rd  = rd;
    e.hit = hit;
    e.irq = irq;
    sb_q.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    check({e.tag, "_rd"},  {24'd0, bus.O_RD_DATA}, {24'd0, e.rd});
    check({e.tag, "_hit"}, {31'd0, bus.O_RD_HIT},  {31'd0, e.hit});
    check({e.tag, "_irq"}, {31'd0, int_req},       {31'd0, e.irq});
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle write strobe; returns on the falling edge after the write edge
  task automatic write_p1(input logic [15:0] addr, input logic [7:0] data);
    bus.I_ADDR    = addr;
    bus.I_WR_DATA = data;
    bus.I_WR_EN   = 1'b1;
    tick(1);
    bus.I_WR_EN   = 1'b0;
    bus.I_ADDR    = 16'hFF00;
  endtask

  // Pulse counter sampled well clear of both clock edges
  always @(posedge clk) begin
    #2;
    if (rst_n && int_req) irq_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    rst_n         = 1'b0;
    buttons       = 8'h00;
    bus.I_ADDR    = 16'hFF00;
    bus.I_WR_EN   = 1'b0;
    bus.I_WR_DATA = 8'h00;
    tick(2);
    rst_n = 1'b1;

    // Reset state, nothing pressed
    tick(3);
    expect_out("reset", P1_RESET_VALUE, 1'b1, 1'b0);
    compare_out();

    // Select the button group; nothing pressed so no interrupt
    write_p1(16'hFF00, 8'h10);
    expect_out("sel_btn", 8'hDF, 1'b1, 1'b0);
    compare_out();

    // Glitch of A shorter than the debounce window never lands
    buttons = 8'h01;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) buttons = 8'h00;
      tick(1);
      expect_out("glitch", 8'hDF, 1'b1, 1'b0);
      compare_out();
    end
    check("glitch_irq_cnt", irq_cnt, 0);

    // Press A: visible exactly 3+DEB cycles later, then one interrupt pulse
    buttons = 8'h01;
    tick(DEB + 2);
    expect_out("press_a_early", 8'hDF, 1'b1, 1'b0);
    compare_out();
    tick(1);
    expect_out("press_a_commit", 8'hDE, 1'b1, 1'b0);
    compare_out();
    tick(1);
    expect_out("press_a_pulse", 8'hDE, 1'b1, 1'b1);
    compare_out();
    tick(1);
    expect_out("press_a_pulse_end", 8'hDE, 1'b1, 1'b0);
    compare_out();
    tick(3);
    check("press_a_irq_cnt", irq_cnt, 1);

    // Matrix select with Down+B held
    buttons = 8'h22;
    tick(DEB + 6);
    write_p1(16'hFF00, 8'h20);
    expect_out("mtx_dir", 8'hE7, 1'b1, 1'b0);
    compare_out();
    write_p1(16'hFF00, 8'h10);
    expect_out("mtx_btn", 8'hDD, 1'b1, int_req);
    check("mtx_btn_rd", {24'd0, bus.O_RD_DATA}, 32'hDD);
    sb_q.pop_back();
    write_p1(16'hFF00, 8'h00);
    check("mtx_both_rd", {24'd0, bus.O_RD_DATA}, 32'hC5);
    write_p1(16'hFF00, 8'h30);
    check("mtx_none_rd", {24'd0, bus.O_RD_DATA}, 32'hFF);

    // Interrupt caused by a select write: Start held, sel 11 -> 01
    buttons = 8'h08;
    tick(DEB + 6);
    base = irq_cnt;
    write_p1(16'hFF00, 8'h10);
    expect_out("selint_e0", 8'hD7, 1'b1, 1'b0);
    compare_out();
    tick(1);
    expect_out("selint_e1", 8'hD7, 1'b1, 1'b1);
    compare_out();
    tick(1);
    expect_out("selint_e2", 8'hD7, 1'b1, 1'b0);
    compare_out();
    write_p1(16'hFF00, 8'h30);
    for (int i = 0; i < 3; i++) begin
      expect_out("selint_back", 8'hFF, 1'b1, 1'b0);
      compare_out();
      tick(1);
    end
    check("selint_irq_cnt", irq_cnt, base + 1);

    // Address decode: write to FF01 misses and leaves sel alone
    bus.I_ADDR    = 16'hFF01;
    bus.I_WR_DATA = 8'h00;
    bus.I_WR_EN   = 1'b1;
    #1;
    expect_out("dec_miss", 8'hFF, 1'b0, 1'b0);
    compare_out();
    tick(1);
    bus.I_WR_EN = 1'b0;
    bus.I_ADDR  = 16'hFF00;
    #1;
    expect_out("dec_after", 8'hFF, 1'b1, 1'b0);
    compare_out();

    // Async reset mid-debounce while an interrupt pulse is high
    buttons = 8'h01;
    tick(5);
    write_p1(16'hFF00, 8'h10);
    tick(1);
    expect_out("pre_rst", 8'hD7, 1'b1, 1'b1);
    compare_out();
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", P1_RESET_VALUE, 1'b1, 1'b0);
    compare_out();
    tick(2);
    rst_n = 1'b1;
    tick(DEB + 2);
    expect_out("post_rst_early", 8'hCF, 1'b1, 1'b0);
    compare_out();
    tick(1);
    expect_out("post_rst_commit", 8'hCE, 1'b1, 1'b0);
    compare_out();
    tick(1);
    expect_out("post_rst_pulse", 8'hCE, 1'b1, 1'b1);
    compare_out();

    // Opposing directions: Left+Right with the direction group selected
    write_p1(16'hFF00, 8'h20);
    buttons = 8'hC0;
    tick(DEB + 6);
`ifdef JOYPAD_SOCD_FILTER_EN
    expect_out("socd_lr", 8'hEF, 1'b1, 1'b0);
`else
    expect_out("socd_lr", 8'hEC, 1'b1, 1'b0);
`endif
    compare_out();
    buttons = 8'h40;
    tick(DEB + 6);
    expect_out("left_only", 8'hED, 1'b1, 1'b0);
    compare_out();

    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
